// File: rtl/radio_start_pkg.sv
// Shared types and helpers for the radio-start regenerator.
package radio_start_pkg;

    localparam logic [1:0] StateUnlocked = 2'd0;
    localparam logic [1:0] StateAcquire  = 2'd1;
    localparam logic [1:0] StateLocked   = 2'd2;
    localparam logic [1:0] StateHoldover = 2'd3;

    typedef enum logic [1:0] {
        StUnlocked = StateUnlocked,
        StAcquire  = StateAcquire,
        StLocked   = StateLocked,
        StHoldover = StateHoldover
    } rs_state_e;

    // Period counter must reach N+T, where it saturates while unlocked.
    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned t);
        return (n + t + 1 > 2) ? $clog2(n + t + 1) : 1;
    endfunction

endpackage

// File: rtl/radio_start_regen_if.sv
// Tick input and regenerated pulse/status outputs of the radio-start regenerator.
interface radio_start_regen_if;

    logic       radio_start_10ms;
    logic       radio_start_10ms_stretch;
    logic       radio_start_10ms_regen;
    logic       locked;
    logic       holdover;
    logic [1:0] state;
    logic       phase_err;
    logic [7:0] err_cnt;

    modport master (
        output radio_start_10ms,
        input  radio_start_10ms_stretch,
        input  radio_start_10ms_regen,
        input  locked,
        input  holdover,
        input  state,
        input  phase_err,
        input  err_cnt
    );

    modport slave (
        input  radio_start_10ms,
        output radio_start_10ms_stretch,
        output radio_start_10ms_regen,
        output locked,
        output holdover,
        output state,
        output phase_err,
        output err_cnt
    );

endinterface

// File: rtl/pulse_stretcher.sv
// Restartable stretcher: a trigger raises the output the next cycle for Length cycles.
module pulse_stretcher #(
    parameter int unsigned Length = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trigger_i,
    output logic pulse_o
);

    localparam int unsigned W = (Length > 1) ? $clog2(Length) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         pulse_q, pulse_d;

    // cnt holds the remaining high cycles after the current one.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        if (trigger_i) begin
            cnt_d   = W'(Length - 1);
            pulse_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/radio_start_regen.sv
// Qualifies the raw 10 ms tick, locks to its grid, free-wheels through short gaps
// and drives the regenerated single-cycle and stretched radio-start lines.
module radio_start_regen
    import radio_start_pkg::*;
#(
    parameter int unsigned ClocksFor10ms = 4000000,
    parameter int unsigned TolCycles     = 64,
    parameter int unsigned StretchCycles = 6400,
    parameter int unsigned LockCount     = 3,
    parameter int unsigned HoldoverMax   = 8
) (
    input logic          s_axis_aclk,
    input logic          s_axis_aresetn,
    radio_start_regen_if.slave rs_bus
);

    localparam int unsigned CntW  = cnt_width(ClocksFor10ms, TolCycles);
    localparam int unsigned GoodW = (LockCount > 1) ? $clog2(LockCount + 1) : 1;
    localparam int unsigned HoW   = (HoldoverMax > 1) ? $clog2(HoldoverMax + 1) : 1;

    localparam logic [CntW-1:0] WinLo    = CntW'(ClocksFor10ms - 1 - TolCycles);
    localparam logic [CntW-1:0] WinHi    = CntW'(ClocksFor10ms - 1 + TolCycles);
    localparam logic [CntW-1:0] CntMax   = CntW'(ClocksFor10ms + TolCycles);
    localparam logic [CntW-1:0] CntSynth = CntW'(TolCycles);

    rs_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [HoW-1:0]  ho_q, ho_d;
    logic [7:0]      err_q, err_d;
    logic            regen_q, perr_q;

    logic tick, in_win, deadline, boundary, synth, perr;

    assign tick     = rs_bus.radio_start_10ms;
    assign in_win   = (cnt_q >= WinLo) && (cnt_q <= WinHi);
    assign deadline = (cnt_q == WinHi) && !tick;

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        ho_d     = ho_q;
        boundary = 1'b0;
        synth    = 1'b0;
        perr     = 1'b0;
        unique case (state_q)
            StUnlocked: begin
                if (tick) begin
                    boundary = 1'b1;
                    good_d   = '0;
                    state_d  = StAcquire;
                end
            end
            StAcquire: begin
                if (tick) begin
                    boundary = 1'b1;
                    if (in_win) begin
                        good_d = good_q + GoodW'(1);
                        if (good_q == GoodW'(LockCount - 1)) begin
                            state_d = StLocked;
                        end
                    end else begin
                        perr   = 1'b1;
                        good_d = '0;
                    end
                end else if (deadline) begin
                    state_d = StUnlocked;
                end
            end
            StLocked: begin
                if (tick) begin
                    boundary = 1'b1;
                    if (!in_win) begin
                        perr    = 1'b1;
                        good_d  = '0;
                        state_d = StAcquire;
                    end
                end else if (deadline) begin
                    boundary = 1'b1;
                    synth    = 1'b1;
                    ho_d     = HoW'(1);
                    state_d  = StHoldover;
                end
            end
            StHoldover: begin
                if (tick) begin
                    boundary = 1'b1;
                    ho_d     = '0;
                    if (in_win) begin
                        state_d = StLocked;
                    end else begin
                        perr    = 1'b1;
                        good_d  = '0;
                        state_d = StAcquire;
                    end
                end else if (deadline) begin
                    if (ho_q < HoW'(HoldoverMax)) begin
                        boundary = 1'b1;
                        synth    = 1'b1;
                        ho_d     = ho_q + HoW'(1);
                    end else begin
                        ho_d    = '0;
                        state_d = StUnlocked;
                    end
                end
            end
            default: state_d = StUnlocked;
        endcase
    end

    // Synthetic boundaries restart at T so the free-wheeling grid stays on nominal.
    always_comb begin
        if (synth) begin
            cnt_d = CntSynth;
        end else if (boundary) begin
            cnt_d = '0;
        end else if (state_q == StUnlocked && cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        err_d = err_q;
        if (perr && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= StUnlocked;
            cnt_q   <= '0;
            good_q  <= '0;
            ho_q    <= '0;
            err_q   <= '0;
            regen_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            ho_q    <= ho_d;
            err_q   <= err_d;
            regen_q <= boundary;
            perr_q  <= perr;
        end
    end

    pulse_stretcher #(
        .Length (StretchCycles)
    ) u_stretch (
        .clk_i     (s_axis_aclk),
        .rst_ni    (s_axis_aresetn),
        .trigger_i (boundary),
        .pulse_o   (rs_bus.radio_start_10ms_stretch)
    );

    assign rs_bus.radio_start_10ms_regen = regen_q;
    assign rs_bus.locked                 = (state_q == StLocked);
    assign rs_bus.holdover               = (state_q == StHoldover);
    assign rs_bus.state                  = state_q;
    assign rs_bus.phase_err              = perr_q;
    assign rs_bus.err_cnt                = err_q;

endmodule

// File: tb/tb_radio_start_regen.sv
// Directed bench for radio_start_regen with N=100, T=4, stretch=10, lock=3, holdover=2.
module tb_radio_start_regen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    radio_start_regen_if rs_bus ();

    radio_start_regen #(
        .ClocksFor10ms (100),
        .TolCycles     (4),
        .StretchCycles (10),
        .LockCount     (3),
        .HoldoverMax   (2)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .rs_bus         (rs_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gap;
        int exp_state;
        int exp_perr;
        int exp_err;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur      = 0;
    int   last_tick = 0;
    int   extra    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cur++;
    endtask

    // Idle until last_tick+gap, counting regens seen on the way, then tick once.
    task automatic tick_gap(input int gap);
        extra = 0;
        while (cur < last_tick + gap) begin
            step();
            if (rs_bus.radio_start_10ms_regen) extra++;
        end
        rs_bus.radio_start_10ms = 1'b1;
        last_tick = cur;
        step();
        rs_bus.radio_start_10ms = 1'b0;
    endtask

    initial begin
        int t, rel, first_rg, second_rg, n_rg, late_st, cnt;
        int st150, ho150, st305, lk305;

        vecs[0] = '{gap: 50,  exp_state: 1, exp_perr: 0, exp_err: 0};
        vecs[1] = '{gap: 100, exp_state: 1, exp_perr: 0, exp_err: 0};
        vecs[2] = '{gap: 100, exp_state: 1, exp_perr: 0, exp_err: 0};
        vecs[3] = '{gap: 100, exp_state: 2, exp_perr: 0, exp_err: 0};
        vecs[4] = '{gap: 96,  exp_state: 2, exp_perr: 0, exp_err: 0};
        vecs[5] = '{gap: 104, exp_state: 2, exp_perr: 0, exp_err: 0};
        vecs[6] = '{gap: 100, exp_state: 2, exp_perr: 0, exp_err: 0};
        vecs[7] = '{gap: 95,  exp_state: 1, exp_perr: 1, exp_err: 1};

        rs_bus.radio_start_10ms = 1'b0;
        #23;
        check("rst_state", int'(rs_bus.state), 0);
        check("rst_stretch", int'(rs_bus.radio_start_10ms_stretch), 0);
        check("rst_regen", int'(rs_bus.radio_start_10ms_regen), 0);
        check("rst_locked", int'(rs_bus.locked), 0);
        check("rst_holdover", int'(rs_bus.holdover), 0);
        check("rst_perr", int'(rs_bus.phase_err), 0);
        check("rst_err_cnt", int'(rs_bus.err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
        last_tick = 0;

        // Lock then window edges.
        for (int i = 0; i < 8; i++) begin
            tick_gap(vecs[i].gap);
            check($sformatf("v%0d_regen", i), int'(rs_bus.radio_start_10ms_regen), 1);
            check($sformatf("v%0d_stretch", i), int'(rs_bus.radio_start_10ms_stretch), 1);
            check($sformatf("v%0d_extra_regen", i), extra, 0);
            check($sformatf("v%0d_state", i), int'(rs_bus.state), vecs[i].exp_state);
            check($sformatf("v%0d_locked", i), int'(rs_bus.locked),
                  (vecs[i].exp_state == 2) ? 1 : 0);
            check($sformatf("v%0d_perr", i), int'(rs_bus.phase_err), vecs[i].exp_perr);
            check($sformatf("v%0d_err_cnt", i), int'(rs_bus.err_cnt), vecs[i].exp_err);
        end

        // Stretch width after the out-of-window tick.
        cnt = 0;
        while (rs_bus.radio_start_10ms_stretch && cnt < 50) begin
            cnt++;
            step();
        end
        check("stretch_len", cnt, 10);
        check("perr_single", int'(rs_bus.phase_err), 0);

        // Relock from ACQUIRE then let ticks stop.
        for (int i = 0; i < 3; i++) tick_gap(100);
        check("relock_locked", int'(rs_bus.locked), 1);
        t = last_tick;
        first_rg = -1; second_rg = -1; n_rg = 0; late_st = 0;
        st150 = -1; ho150 = -1; st305 = -1; lk305 = -1;
        while (cur < t + 320) begin
            step();
            rel = cur - t;
            if (rs_bus.radio_start_10ms_regen) begin
                n_rg++;
                if (first_rg < 0) first_rg = rel;
                else if (second_rg < 0) second_rg = rel;
            end
            if (rel >= 215 && rs_bus.radio_start_10ms_stretch) late_st++;
            if (rel == 150) begin
                st150 = int'(rs_bus.state);
                ho150 = int'(rs_bus.holdover);
            end
            if (rel == 305) begin
                st305 = int'(rs_bus.state);
                lk305 = int'(rs_bus.locked);
            end
        end
        check("ho_first_regen", first_rg, 105);
        check("ho_second_regen", second_rg, 205);
        check("ho_regen_count", n_rg, 2);
        check("ho_state", st150, 3);
        check("ho_flag", ho150, 1);
        check("ho_expire_state", st305, 0);
        check("ho_expire_locked", lk305, 0);
        check("ho_late_stretch", late_st, 0);

        // Holdover recovery with a tick 200 cycles after the last real one.
        last_tick = cur;
        tick_gap(10);
        for (int i = 0; i < 3; i++) tick_gap(100);
        check("rec_locked_pre", int'(rs_bus.state), 2);
        tick_gap(200);
        check("rec_synth_count", extra, 1);
        check("rec_regen", int'(rs_bus.radio_start_10ms_regen), 1);
        check("rec_state", int'(rs_bus.state), 2);
        check("rec_holdover", int'(rs_bus.holdover), 0);
        n_rg = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (rs_bus.radio_start_10ms_regen) n_rg++;
        end
        check("rec_no_dup", n_rg, 0);

        // Reset three cycles into a stretch.
        tick_gap(100);
        check("mid_state", int'(rs_bus.state), 2);
        step();
        step();
        check("mid_stretch_hi", int'(rs_bus.radio_start_10ms_stretch), 1);
        check("mid_err_cnt", int'(rs_bus.err_cnt), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_stretch", int'(rs_bus.radio_start_10ms_stretch), 0);
        check("async_state", int'(rs_bus.state), 0);
        check("async_err_cnt", int'(rs_bus.err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check("post_state", int'(rs_bus.state), 0);
        check("post_err_cnt", int'(rs_bus.err_cnt), 0);
        check("post_stretch", int'(rs_bus.radio_start_10ms_stretch), 0);
        check("post_locked", int'(rs_bus.locked), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/radio_start_regen.md
Name: radio_start_regen

Overview:
- Transmit-side counterpart of the radio-start recovery logic. It takes the raw single-cycle 10 ms radio-start tick from the timing source and drives the stretched 10 ms pulse line that downstream recovery blocks decode.
- It qualifies tick spacing and locks to a period-locked grid. When ticks go missing it free-wheels for a bounded number of periods. It reports lock, holdover and phase-error status.
- It sits between the torwave timing outputs and the cross-board or cross-domain radio-start distribution.

Parameters:
- clocks_for_10ms, 4000000, nominal tick period N in clocks.
- tol_cycles, 64, accepted tick jitter ±T around the expected tick.
- stretch_cycles, 6400, high time of the stretched pulse. Must satisfy stretch_cycles < N-T.
- lock_count, 3, consecutive in-window ticks required to lock.
- holdover_max, 8, synthetic boundaries allowed before dropping lock.

Ports:
- s_axis_aclk  in  1  sole clock.
- s_axis_aresetn  in  1  asynchronous active-low reset.
- radio_start_10ms  in  1  raw tick, single-cycle, synchronous to s_axis_aclk.
- radio_start_10ms_stretch  out  1  stretched pulse, registered.
- radio_start_10ms_regen  out  1  single-cycle regenerated boundary, registered.
- locked  out  1  state==LOCKED.
- holdover  out  1  state==HOLDOVER.
- state  out  2  0=UNLOCKED, 1=ACQUIRE, 2=LOCKED, 3=HOLDOVER.
- phase_err  out  1  single-cycle pulse on an out-of-window tick.
- err_cnt  out  8  count of phase_err pulses, saturating at 255.

Behaviour:
- Reset: state=UNLOCKED; cnt, good_cnt, ho_cnt and stretch counter all 0; every output 0. Reset asserted mid-stretch drops the stretch immediately.
- Period counter cnt:
  - Width clog2(N+T+1).
  - Next value is 0 after any boundary, otherwise cnt+1.
  - Saturates at N+T in UNLOCKED.
  - With ticks exactly N apart, cnt==N-1 on the tick cycle.
- In-window test: N-1-T ≤ cnt ≤ N-1+T. Deadline: cnt==N-1+T with no tick that cycle.
- Boundary event:
  - regen pulses one cycle after the event.
  - stretch goes high the cycle after the event and holds for stretch_cycles cycles.
  - A new event while stretch is high restarts the stretch count; the line stays high.
- UNLOCKED:
  - Any tick: boundary, good_cnt=0, go to ACQUIRE.
  - No deadline handling in this state.
- ACQUIRE:
  - In-window tick: boundary, good_cnt+1. If good_cnt reaches lock_count, go to LOCKED.
  - Out-of-window tick: boundary, phase_err, good_cnt=0, stay in ACQUIRE.
  - Deadline: go to UNLOCKED, no boundary.
- LOCKED:
  - In-window tick: boundary, stay in LOCKED.
  - Out-of-window tick: boundary, phase_err, good_cnt=0, go to ACQUIRE.
  - Deadline: synthetic boundary, ho_cnt=1, next cnt=T (keeps the nominal grid), go to HOLDOVER.
- HOLDOVER:
  - In-window tick: boundary, ho_cnt=0, go to LOCKED.
  - Out-of-window tick: boundary, phase_err, go to ACQUIRE.
  - Deadline with ho_cnt<holdover_max: synthetic boundary, ho_cnt+1, next cnt=T.
  - Deadline with ho_cnt==holdover_max: go to UNLOCKED, no boundary.
- Tick coincident with the deadline cycle: the tick wins and counts as in-window; no synthetic boundary.
- Latency: tick to regen/stretch rise is exactly 1 clock in all states.

Decomposition:
- Shared package radio_start_pkg holds:
  - typedef rs_state_e (UNLOCKED, ACQUIRE, LOCKED, HOLDOVER);
  - the state encoding constants;
  - a function computing the counter width from N+T.
- One sub-module, pulse_stretcher: restartable down-counter with a trigger input, a length parameter and a registered output.

Test Plan (N=100, T=4, stretch_cycles=10, lock_count=3, holdover_max=2):
- Reset:
  - Stimulus: assert aresetn low asynchronously, no ticks.
  - Required: all outputs 0, state=0.
- Lock:
  - Stimulus: 4 ticks spaced 100 cycles.
  - Required: ACQUIRE after tick 1; locked=1 the cycle after tick 4.
  - Required: each tick gives regen one cycle later and stretch high exactly 10 cycles.
- Window edges (while locked):
  - Spacings of 96 and 104: accepted, locked stays 1, phase_err 0.
  - Spacing of 95: phase_err=1, err_cnt=1, state=ACQUIRE.
- Holdover:
  - Stimulus: stop ticks after lock.
  - Required: synthetic regens 104 and 204 cycles after the last tick; holdover=1.
  - Required: at 304 cycles, state=UNLOCKED with no further stretch.
- Holdover recovery:
  - Stimulus: in HOLDOVER, tick 200 cycles after the last real tick.
  - Required: state=LOCKED, regen at tick+1, no duplicate synthetic boundary.
- Reset mid-operation:
  - Stimulus: assert reset 3 cycles into a stretch.
  - Required: stretch falls immediately; after release, state=UNLOCKED and err_cnt=0.
